// File: rtl/hex_word_parser_pkg.sv
// Shared ASCII constants and parser state encoding for hex_word_parser.
package hex_word_parser_pkg;

    localparam int unsigned CHAR_W = 7;

    localparam logic [CHAR_W-1:0] ASCII_0       = 7'h30;
    localparam logic [CHAR_W-1:0] ASCII_9       = 7'h39;
    localparam logic [CHAR_W-1:0] ASCII_UPPER_A = 7'h41;
    localparam logic [CHAR_W-1:0] ASCII_UPPER_F = 7'h46;
    localparam logic [CHAR_W-1:0] ASCII_LOWER_A = 7'h61;
    localparam logic [CHAR_W-1:0] ASCII_LOWER_F = 7'h66;
    localparam logic [CHAR_W-1:0] ASCII_SPACE   = 7'h20;
    localparam logic [CHAR_W-1:0] ASCII_CR      = 7'h0D;
    localparam logic [CHAR_W-1:0] ASCII_LF      = 7'h0A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DISCARD = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_e;

endpackage

// File: rtl/hex_digit_decode.sv
// Combinational ASCII classifier: hex digit -> nibble, plus terminator detect.
// Lowercase a-f accepted only when HEX_WORD_PARSER_LOWERCASE_EN is defined.
module hex_digit_decode
    import hex_word_parser_pkg::*;
(
    input  logic [CHAR_W-1:0] ch,
    output logic [3:0]        nibble,
    output logic              is_digit,
    output logic              is_terminator
);

    always_comb begin
        nibble        = 4'd0;
        is_digit      = 1'b0;
        is_terminator = 1'b0;
        if (ch >= ASCII_0 && ch <= ASCII_9) begin
            nibble   = 4'(ch - ASCII_0);
            is_digit = 1'b1;
        end else if (ch >= ASCII_UPPER_A && ch <= ASCII_UPPER_F) begin
            nibble   = 4'(ch - ASCII_UPPER_A + 7'd10);
            is_digit = 1'b1;
`ifdef HEX_WORD_PARSER_LOWERCASE_EN
        end else if (ch >= ASCII_LOWER_A && ch <= ASCII_LOWER_F) begin
            nibble   = 4'(ch - ASCII_LOWER_A + 7'd10);
            is_digit = 1'b1;
`endif
        end else if (ch == ASCII_SPACE || ch == ASCII_CR || ch == ASCII_LF) begin
            is_terminator = 1'b1;
        end
    end

endmodule

// File: rtl/hex_word_parser.sv
// ASCII hex character stream -> binary word parser with malformed-input error pulse.
// Optional lowercase digits via HEX_WORD_PARSER_LOWERCASE_EN (see hex_digit_decode).
module hex_word_parser
    import hex_word_parser_pkg::*;
#(
    parameter  int unsigned DIGITS = 8,
    localparam int unsigned WORD_W = 4 * DIGITS,
    localparam int unsigned CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              char_valid,
    input  logic [CHAR_W-1:0] char_data,
    output logic              char_ready,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic [CNT_W-1:0]  word_digits,
    input  logic              word_ready,
    output logic              error
);

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WORD_W-1:0]  word_data_q, word_data_d;
    logic [CNT_W-1:0]   word_digits_q, word_digits_d;
    logic               word_valid_q, word_valid_d;
    logic               error_q, error_d;

    logic [3:0]         nibble;
    logic               is_digit;
    logic               is_term;
    logic               char_fire;
    logic               acc_full;

    hex_digit_decode u_decode (
        .ch            (char_data),
        .nibble        (nibble),
        .is_digit      (is_digit),
        .is_terminator (is_term)
    );

    assign char_ready = (state_q != ST_OUTPUT);
    assign char_fire  = char_valid && char_ready;
    assign acc_full   = (count_q == CNT_W'(DIGITS));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            count_q       <= '0;
            word_data_q   <= '0;
            word_digits_q <= '0;
            word_valid_q  <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            count_q       <= count_d;
            word_data_q   <= word_data_d;
            word_digits_q <= word_digits_d;
            word_valid_q  <= word_valid_d;
            error_q       <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (char_fire) begin
                    if (is_digit)     state_d = ST_ACCUM;
                    else if (!is_term) state_d = ST_DISCARD;
                end
            end
            ST_ACCUM: begin
                if (char_fire) begin
                    if (is_digit) begin
                        if (acc_full) state_d = ST_DISCARD;
                    end else if (is_term) begin
                        state_d = ST_OUTPUT;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                if (char_fire && is_term) state_d = ST_IDLE;
            end
            ST_OUTPUT: begin
                if (word_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; error defaults low so it pulses for one cycle.
    always_comb begin
        acc_d         = acc_q;
        count_d       = count_q;
        word_data_d   = word_data_q;
        word_digits_d = word_digits_q;
        word_valid_d  = word_valid_q;
        error_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (char_fire) begin
                    if (is_digit) begin
                        acc_d   = WORD_W'(nibble);
                        count_d = CNT_W'(1);
                    end else if (!is_term) begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (char_fire) begin
                    if (is_digit) begin
                        if (acc_full) begin
                            error_d = 1'b1;
                        end else begin
                            acc_d   = WORD_W'({acc_q, nibble});
                            count_d = count_q + CNT_W'(1);
                        end
                    end else if (is_term) begin
                        word_data_d   = acc_q;
                        word_digits_d = count_q;
                        word_valid_d  = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (char_fire && is_term) begin
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            ST_OUTPUT: begin
                if (word_ready) begin
                    word_valid_d = 1'b0;
                    acc_d        = '0;
                    count_d      = '0;
                end
            end
            default: begin
                acc_d   = '0;
                count_d = '0;
            end
        endcase
    end

    assign word_valid  = word_valid_q;
    assign word_data   = word_data_q;
    assign word_digits = word_digits_q;
    assign error       = error_q;

endmodule

// File: tb/tb_hex_word_parser.sv
// Directed self-checking bench for hex_word_parser (DIGITS = 8).
module tb_hex_word_parser;

    localparam int unsigned DIGITS = 8;
    localparam logic [6:0]  CH_CR  = 7'h0D;
    localparam logic [6:0]  CH_LF  = 7'h0A;
    localparam logic [6:0]  CH_SP  = 7'h20;

    logic        clock = 1'b0;
    logic        reset;
    logic        char_valid;
    logic [6:0]  char_data;
    logic        char_ready;
    logic        word_valid;
    logic [31:0] word_data;
    logic [3:0]  word_digits;
    logic        word_ready;
    logic        error;

    int n_vec  = 0;
    int n_miss = 0;

    hex_word_parser #(.DIGITS(DIGITS)) dut (
        .clock       (clock),
        .reset       (reset),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_ready  (char_ready),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_digits (word_digits),
        .word_ready  (word_ready),
        .error       (error)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_char(input logic [6:0] c);
        int waited = 0;
        while (!char_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!char_ready) begin
            check_val("char_ready_timeout", 64'(char_ready), 64'd1);
            return;
        end
        char_valid = 1'b1;
        char_data  = c;
        step();
        char_valid = 1'b0;
        char_data  = 7'd0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(7'(s[i]));
    endtask

    // Called right after the terminator edge; hold=1 means word_ready is already high.
    task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] n,
                               input bit hold);
        check_val({tag, "_valid"},  64'(word_valid),  64'd1);
        check_val({tag, "_data"},   64'(word_data),   64'(d));
        check_val({tag, "_digits"}, 64'(word_digits), 64'(n));
        check_val({tag, "_cready"}, 64'(char_ready),  64'd0);
        if (!hold) begin
            step();
            step();
            check_val({tag, "_hold_valid"}, 64'(word_valid), 64'd1);
            check_val({tag, "_hold_data"},  64'(word_data),  64'(d));
            word_ready = 1'b1;
            step();
            word_ready = 1'b0;
        end else begin
            step();
        end
        check_val({tag, "_accepted"}, 64'(word_valid), 64'd0);
        check_val({tag, "_cready_back"}, 64'(char_ready), 64'd1);
    endtask

    initial begin
        reset      = 1'b1;
        char_valid = 1'b0;
        char_data  = 7'd0;
        word_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check_val("rst_word_valid",  64'(word_valid),  64'd0);
        check_val("rst_word_data",   64'(word_data),   64'd0);
        check_val("rst_word_digits", 64'(word_digits), 64'd0);
        check_val("rst_error",       64'(error),       64'd0);
        check_val("rst_char_ready",  64'(char_ready),  64'd1);

        // 1A3<CR>, consumer stalls before accepting
        send_str("1A3");
        check_val("t1_no_error", 64'(error), 64'd0);
        check_val("t1_no_early_word", 64'(word_valid), 64'd0);
        send_char(CH_CR);
        expect_word("t1", 32'h0000_01A3, 4'd3, 1'b0);

        // Two words with word_ready held high throughout
        word_ready = 1'b1;
        step();
        check_val("t2_idle_ready_noop", 64'(word_valid), 64'd0);
        send_str("DEADBEEF ");
        expect_word("t2a", 32'hDEAD_BEEF, 4'd8, 1'b1);
        send_char(7'h37);
        send_char(CH_LF);
        expect_word("t2b", 32'h0000_0007, 4'd1, 1'b1);
        word_ready = 1'b0;

        // Overflow at ninth digit
        for (int i = 1; i <= 8; i++) send_char(7'(7'h30 + i));
        check_val("t3_eight_ok", 64'(error), 64'd0);
        send_char(7'h39);
        check_val("t3_ovf_error", 64'(error), 64'd1);
        step();
        check_val("t3_error_pulse", 64'(error), 64'd0);
        send_char(CH_CR);
        check_val("t3_no_word", 64'(word_valid), 64'd0);
        step();
        check_val("t3_no_word_late", 64'(word_valid), 64'd0);
        send_char(7'h35);
        send_char(CH_CR);
        expect_word("t3", 32'h0000_0005, 4'd1, 1'b0);

        // Invalid character mid-word, then lowercase handling
        send_str("1G");
        check_val("t4_g_error", 64'(error), 64'd1);
        send_char(7'h32);
        check_val("t4_discard_quiet", 64'(error), 64'd0);
        send_char(CH_CR);
        check_val("t4_no_word", 64'(word_valid), 64'd0);
        send_char(7'h61);
`ifdef HEX_WORD_PARSER_LOWERCASE_EN
        check_val("t4_lower_ok", 64'(error), 64'd0);
        send_char(CH_CR);
        expect_word("t4_lower", 32'h0000_000A, 4'd1, 1'b0);
`else
        check_val("t4_lower_error", 64'(error), 64'd1);
        send_char(CH_CR);
        check_val("t4_lower_no_word", 64'(word_valid), 64'd0);
        check_val("t4_lower_quiet", 64'(error), 64'd0);
`endif

        // Bare terminators in IDLE
        send_char(CH_CR);
        send_char(CH_CR);
        send_char(CH_SP);
        check_val("t5_no_word",  64'(word_valid), 64'd0);
        check_val("t5_no_error", 64'(error),      64'd0);
        check_val("t5_ready",    64'(char_ready), 64'd1);
        step();
        check_val("t5_no_word_late", 64'(word_valid), 64'd0);

        // Reset with a word pending
        send_str("FF");
        send_char(CH_CR);
        check_val("t6_pending", 64'(word_valid), 64'd1);
        check_val("t6_pending_data", 64'(word_data), 64'h0000_00FF);
        #2 reset = 1'b1;
        #1;
        check_val("t6_rst_valid",  64'(word_valid),  64'd0);
        check_val("t6_rst_data",   64'(word_data),   64'd0);
        check_val("t6_rst_digits", 64'(word_digits), 64'd0);
        check_val("t6_rst_error",  64'(error),       64'd0);
        check_val("t6_rst_ready",  64'(char_ready),  64'd1);
        step();
        reset = 1'b0;
        step();
        check_val("t6_post_rst_error", 64'(error), 64'd0);
        send_char(7'h32);
        send_char(CH_CR);
        expect_word("t6", 32'h0000_0002, 4'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hex_word_parser.md
# hex_word_parser

Parses a stream of 7-bit ASCII characters into binary words, the inverse of the team's binary-to-ASCII-hex digit encoder. Sits between a UART/console receiver and command/register logic: accumulates uppercase hex digits, emits the word on a terminator, and flags malformed input. Byte-stream valid/ready on input; word valid/ready on output.

## Interface
- `DIGITS`, default 8, maximum hex digits per word (1..16)
- `clock`  in  1  system clock, all logic rising-edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `char_valid`  in  1  input character present
- `char_data`  in  7  ASCII character
- `char_ready`  out  1  parser accepts a character this cycle
- `word_valid`  out  1  parsed word held on `word_data`
- `word_data`  out  4*DIGITS  parsed value, right-aligned, zero-extended
- `word_digits`  out  clog2(DIGITS+1)  digit count of held word (1..DIGITS)
- `word_ready`  in  1  consumer accepts word
- `error`  out  1  one-cycle pulse on malformed input

## Operation
- Character accepted when `char_valid && char_ready`; word accepted when `word_valid && word_ready`.
- Digit: `0`-`9` (0x30-0x39) -> 0-9, `A`-`F` (0x41-0x46) -> 10-15. Terminator: space 0x20, CR 0x0D, LF 0x0A. Anything else is invalid.
- States: IDLE, ACCUM, DISCARD, OUTPUT.
- IDLE: digit -> acc = nibble, count = 1, ACCUM. Terminator -> ignored, stay. Invalid -> `error`, DISCARD.
- ACCUM: digit with count < DIGITS -> acc = {acc[4*DIGITS-5:0], nibble}, count+1. Digit with count == DIGITS -> `error`, DISCARD (overflow). Terminator -> latch acc/count to outputs, OUTPUT. Invalid -> `error`, DISCARD.
- DISCARD: all characters consumed; terminator -> IDLE, acc/count cleared; no word emitted.
- OUTPUT: `char_ready` = 0, `word_valid` = 1, `word_data`/`word_digits` stable until accepted; on acceptance -> IDLE, acc/count cleared.
- Leading zeros counted as digits (`0001` = 4 digits, value 1).

## Timing
- Reset values: state IDLE, `word_valid` 0, `word_data` 0, `word_digits` 0, `error` 0, `char_ready` 1.
- `char_ready` = (state != OUTPUT), combinational from state register.
- `word_valid` rises the cycle after the terminator is accepted.
- `error` asserted exactly one cycle, the cycle after the offending character is accepted.
- Word acceptance cycle: `char_ready` still 0; first new character accepted the following cycle. No same-cycle word accept/char accept.
- `word_ready` held high with no word pending: no effect.
- Back-to-back terminators: second one in IDLE ignored, no empty word.
- Reset mid-word or with word pending: word dropped, no `error`.

## Configuration
- `HEX_WORD_PARSER_LOWERCASE_EN` defined: `a`-`f` (0x61-0x66) also decode to 10-15.
- Undefined: lowercase letters are invalid characters (`error`, DISCARD).

## Structure
- Shared package: ASCII constants (digit/letter ranges, SPACE, CR, LF), state enum encoding.
- Sub-module `hex_digit_decode`: combinational, 7-bit char -> 4-bit nibble, `is_digit`, `is_terminator`; contains the lowercase macro guard. Parser FSM/datapath in the top.

## Test plan
- Stream `1`,`A`,`3`,CR (DIGITS=8) -> `word_valid`, `word_data`=0x000001A3, `word_digits`=3, one cycle after CR; holds while `word_ready`=0.
- `DEADBEEF`,space then `7`,LF with `word_ready` high -> words 0xDEADBEEF (8 digits) then 0x00000007 (1); `char_ready` low during each OUTPUT cycle.
- `123456789`,CR (DIGITS=8) -> `error` pulse after `9`, no word; subsequent `5`,CR -> 0x5.
- `1G2`,CR -> `error` after `G`, no word; `a`,CR -> word 0xA with macro defined, `error` and no word without.
- CR,CR,space in IDLE -> no `word_valid`, no `error`, `char_ready` stays 1.
- `FF`,CR, word pending, assert `reset` -> all outputs to reset values; then `2`,CR -> 0x2, 1 digit.
